alu_iter: RTL and testbench

Parametrised iterative integer ALU; successor to the fixed 32-bit combinational integer/shift/logic calculators in the ALU board designs. A start/done handshake accepts one operation at a time. Add, sub, logic and shift ops complete in one cycle. Multiply and divide run as WIDTH-step shift-add and restoring-divide state machines. It sits between the operand-entry block (A/B registers) and the display mux; result_hi/result_lo feed the 64-bit display word and the flag outputs feed the LED driver.

---
 rtl/alu_iter_if.sv | 27 ++
 rtl/alu_iter.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_iter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_if.sv
// Handshake and result bus between the operand-entry block and alu_iter.
interface alu_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             carry;
   logic             overflow;
   logic             zero;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result_lo, result_hi, carry, overflow, zero, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result_lo, result_hi, carry, overflow, zero, div_zero
   );
endinterface

// File: rtl/alu_iter.sv
// Iterative integer ALU: single-cycle add/sub/logic/shift, WIDTH-step multiply and divide.
// Define ALU_ITER_SIGNED_EN to enable signed multiply (op 13) and divide (op 14).
module alu_iter #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       rst,
   alu_iter_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE
`ifdef ALU_ITER_SIGNED_EN
      , S_FIX
`endif
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a, r_b, r_acc, r_q, r_m, r_lo, r_hi;
   logic             r_busy, r_done, r_carry, r_ovf, r_zero, r_dz;

   // Rotates reuse one doubled-operand shifter; rol is ror by the complementary amount.
   function automatic logic [WIDTH-1:0] f_shift(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                                input logic [SHW-1:0] sh);
      logic [2*WIDTH-1:0] dbl;
      int                 rot;
      rot = int'(sh) % WIDTH;
      dbl = {x, x};
      case (op)
         4'd8:    return x >> sh;
         4'd9:    return x << sh;
         4'd10:   return WIDTH'(dbl >> rot);
         4'd11:   return WIDTH'(dbl >> ((WIDTH - rot) % WIDTH));
         default: return WIDTH'($signed(x) >>> sh);
      endcase
   endfunction

   logic             w_go_mul, w_go_div, w_sgn;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;

`ifdef ALU_ITER_SIGNED_EN
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
      return ~x + 1'b1;
   endfunction

   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? f_neg(x) : x;
   endfunction

   assign w_go_mul = (bus.op == 4'd2) || (bus.op == 4'd13);
   assign w_go_div = (bus.op == 4'd3) || (bus.op == 4'd14);
   assign w_sgn    = (r_op == 4'd13) || (r_op == 4'd14);
   assign w_a_mag  = w_sgn ? f_abs(r_a) : r_a;
   assign w_b_mag  = w_sgn ? f_abs(r_b) : r_b;
`else
   assign w_go_mul = (bus.op == 4'd2);
   assign w_go_div = (bus.op == 4'd3);
   assign w_sgn    = 1'b0;
   assign w_a_mag  = r_a;
   assign w_b_mag  = r_b;
`endif

   logic [WIDTH:0]   w_add, w_sub, w_madd, w_rsh;
   logic [WIDTH-1:0] w_trial, w_nx_acc, w_nx_q;
   logic             w_ge, w_last, w_bz;

   assign w_add   = {1'b0, r_a} + {1'b0, r_b};
   assign w_sub   = {1'b0, r_a} - {1'b0, r_b};
   // Multiply: r_acc:r_q is the {acc, multiplier} pair. Divide: r_acc is the partial remainder.
   assign w_madd  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
   assign w_rsh   = {r_acc, r_q[WIDTH-1]};
   assign w_ge    = (w_rsh >= {1'b0, r_m});
   assign w_trial = w_rsh[WIDTH-1:0] - r_m;
   assign w_nx_acc = (r_state == S_MUL) ? w_madd[WIDTH:1]
                                        : (w_ge ? w_trial : w_rsh[WIDTH-1:0]);
   assign w_nx_q   = (r_state == S_MUL) ? {w_madd[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], w_ge};
   assign w_last   = (r_cnt == LAST);
   assign w_bz     = (r_b == '0);

   logic             w_fin, w_rsvd, w_c, w_v, w_dz, w_z;
   logic [WIDTH-1:0] w_lo, w_hi;

   always_comb begin
      w_fin  = 1'b0;
      w_rsvd = 1'b0;
      w_lo   = '0;
      w_hi   = '0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      w_dz   = 1'b0;
      case (r_state)
         S_EXEC: begin
            w_fin = 1'b1;
            case (r_op)
               4'd0: begin
                  w_lo = w_add[WIDTH-1:0];
                  w_c  = w_add[WIDTH];
                  w_v  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
               end
               4'd1: begin
                  w_lo = w_sub[WIDTH-1:0];
                  w_c  = w_sub[WIDTH];
                  w_v  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
               end
               4'd4:    w_lo = r_a & r_b;
               4'd5:    w_lo = r_a | r_b;
               4'd6:    w_lo = r_a ^ r_b;
               4'd7:    w_lo = ~r_a;
               4'd8, 4'd9, 4'd10, 4'd11, 4'd12: w_lo = f_shift(r_op, r_a, r_b[SHW-1:0]);
               default: w_rsvd = 1'b1;
            endcase
         end
         S_MUL: begin
            if (w_last && !w_sgn) begin
               w_fin = 1'b1;
               w_lo  = w_nx_q;
               w_hi  = w_nx_acc;
            end
         end
         S_DIV: begin
            if ((r_cnt != '0) && w_bz) begin
               w_fin = 1'b1;
               w_lo  = '1;
               w_hi  = r_a;
               w_dz  = 1'b1;
            end else if (w_last && !w_sgn) begin
               w_fin = 1'b1;
               w_lo  = w_nx_q;
               w_hi  = w_nx_acc;
            end
         end
`ifdef ALU_ITER_SIGNED_EN
         S_FIX: begin
            w_fin = 1'b1;
            if (r_op == 4'd13) begin
               {w_hi, w_lo} = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (~{r_acc, r_q}) + 1'b1 : {r_acc, r_q};
            end else begin
               w_lo = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? f_neg(r_q) : r_q;
               w_hi = r_a[WIDTH-1] ? f_neg(r_acc) : r_acc;
               w_v  = (r_a == SMIN) && (r_b == '1);
            end
         end
`endif
         default: ;
      endcase
      w_z = !w_rsvd && ({w_hi, w_lo} == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         if (w_fin) begin
            r_lo    <= w_lo;
            r_hi    <= w_hi;
            r_carry <= w_c;
            r_ovf   <= w_v;
            r_zero  <= w_z;
            r_dz    <= w_dz;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
               if (bus.start) begin
                  r_op   <= bus.op;
                  r_a    <= bus.a;
                  r_b    <= bus.b;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (w_go_mul)      r_state <= S_MUL;
                  else if (w_go_div) r_state <= S_DIV;
                  else               r_state <= S_EXEC;
               end
            end
            S_EXEC: r_state <= S_DONE;
            // Count 0 loads operand magnitudes; counts 1..WIDTH are the iterations.
            S_MUL, S_DIV: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == '0) begin
                  r_acc <= '0;
                  r_q   <= w_a_mag;
                  r_m   <= w_b_mag;
               end else if ((r_state == S_DIV) && w_bz) begin
                  r_state <= S_DONE;
               end else begin
                  r_acc <= w_nx_acc;
                  r_q   <= w_nx_q;
`ifdef ALU_ITER_SIGNED_EN
                  if (w_last) r_state <= w_sgn ? S_FIX : S_DONE;
`else
                  if (w_last) r_state <= S_DONE;
`endif
               end
            end
`ifdef ALU_ITER_SIGNED_EN
            S_FIX: r_state <= S_DONE;
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.result_lo = r_lo;
   assign bus.result_hi = r_hi;
   assign bus.carry     = r_carry;
   assign bus.overflow  = r_ovf;
   assign bus.zero      = r_zero;
   assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=32.
module tb_alu_iter;
   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;
   int   lat;
   int   seen;

   alu_iter_if #(.WIDTH(32)) bus ();
   alu_iter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {bus.carry, bus.overflow, bus.zero, bus.div_zero};
   endfunction

   // Issues one op, scrambles operands after acceptance, returns edges from acceptance to done.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, output int lat_o);
      int n;
      @(negedge clk);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      bus.op    = 4'd0;
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         bus.start = (poke && n >= 4 && n <= 6) ? 1'b1 : 1'b0;
      end
      lat_o = n;
   endtask

   logic [31:0] sh_exp [5];

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 4'd0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", {bus.busy, bus.done}, 0);
      chk("rst_res", {bus.result_hi, bus.result_lo}, 0);
      chk("rst_flags", flags(), 0);
      rst = 1'b0;

      run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
      chk("add_c_lat", lat, 2);
      chk("add_c_res", {bus.result_hi, bus.result_lo}, 0);
      chk("add_c_flags", flags(), 4'b1010);
      chk("add_c_busy", bus.busy, 0);

      run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, lat);
      chk("add_v_lo", bus.result_lo, 32'h8000_0000);
      chk("add_v_flags", flags(), 4'b0100);

      run_op(4'd1, 32'd3, 32'd5, 1'b0, lat);
      chk("sub_b_lo", bus.result_lo, 32'hFFFF_FFFE);
      chk("sub_b_flags", flags(), 4'b1000);

      run_op(4'd1, 32'h8000_0000, 32'd1, 1'b0, lat);
      chk("sub_v_lo", bus.result_lo, 32'h7FFF_FFFF);
      chk("sub_v_flags", flags(), 4'b0100);

      run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
      chk("mulu_lat", lat, 34);
      chk("mulu_res", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFE_0000_0001);
      chk("mulu_flags", flags(), 0);

      run_op(4'd2, 32'd0, 32'd5, 1'b0, lat);
      chk("mulu0_res", {bus.result_hi, bus.result_lo}, 0);
      chk("mulu0_flags", flags(), 4'b0010);

      run_op(4'd3, 32'd100, 32'd7, 1'b0, lat);
      chk("divu_lat", lat, 34);
      chk("divu_res", {bus.result_hi, bus.result_lo}, {32'd2, 32'd14});
      chk("divu_flags", flags(), 0);

      run_op(4'd3, 32'd5, 32'd0, 1'b0, lat);
      chk("divz_lat", lat, 3);
      chk("divz_res", {bus.result_hi, bus.result_lo}, {32'd5, 32'hFFFF_FFFF});
      chk("divz_flags", flags(), 4'b0001);

      sh_exp = '{32'h0800_0000, 32'h0000_0010, 32'h1800_0000, 32'h0000_0018, 32'hF800_0000};
      for (int i = 0; i < 5; i++) begin
         run_op(4'(8 + i), 32'h8000_0001, 32'd4, 1'b0, lat);
         chk($sformatf("shift_op%0d", 8 + i), {bus.result_hi, bus.result_lo}, {32'd0, sh_exp[i]});
      end

      run_op(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
      chk("and_lo", bus.result_lo, 32'hF000_F000);
      run_op(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
      chk("or_lo", bus.result_lo, 32'hFFF0_FFF0);
      run_op(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
      chk("xor_lo", bus.result_lo, 32'h0FF0_0FF0);
      run_op(4'd7, 32'hF0F0_F0F0, 32'd0, 1'b0, lat);
      chk("not_lo", bus.result_lo, 32'h0F0F_0F0F);
      run_op(4'd6, 32'h1234_5678, 32'h1234_5678, 1'b0, lat);
      chk("xor_zero_flags", flags(), 4'b0010);

      run_op(4'd15, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
      chk("rsvd_lat", lat, 2);
      chk("rsvd_res", {bus.result_hi, bus.result_lo}, 0);
      chk("rsvd_flags", flags(), 0);

`ifdef ALU_ITER_SIGNED_EN
      run_op(4'd14, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
      chk("sdiv_lat", lat, 35);
      chk("sdiv_res", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(4'd13, 32'hFFFF_FFFD, 32'd5, 1'b0, lat);
      chk("smul_lat", lat, 35);
      chk("smul_res", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
      chk("sdiv_ovf_res", {bus.result_hi, bus.result_lo}, 64'h0000_0000_8000_0000);
      chk("sdiv_ovf_flags", flags(), 4'b0100);
`else
      run_op(4'd13, 32'hFFFF_FFFD, 32'd5, 1'b0, lat);
      chk("op13_lat", lat, 2);
      chk("op13_res", {bus.result_hi, bus.result_lo}, 0);
      run_op(4'd14, 32'd100, 32'd7, 1'b0, lat);
      chk("op14_lat", lat, 2);
      chk("op14_res", {bus.result_hi, bus.result_lo}, 0);
`endif

      run_op(4'd0, 32'd1, 32'd1, 1'b0, lat);
      chk("pre_rst_lo", bus.result_lo, 32'd2);

      // Abort a multiply with reset sampled at edge 10.
      @(negedge clk);
      bus.op    = 4'd2;
      bus.a     = 32'd6;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("mul_busy", bus.busy, 1);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_ctl", {bus.busy, bus.done}, 0);
      chk("abort_res", {bus.result_hi, bus.result_lo}, 0);
      chk("abort_flags", flags(), 0);
      rst = 1'b0;

      run_op(4'd0, 32'd2, 32'd3, 1'b0, lat);
      chk("post_rst_lat", lat, 2);
      chk("post_rst_lo", bus.result_lo, 32'd5);
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) seen++;
      end
      chk("abort_no_done", seen, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
